bmp_stream_parser: RTL and testbench

Synthesizable BMP decoder. Consumes a raw .bmp file as a byte stream, one byte per cycle, under a valid/ready handshake. Parses the 54-byte header into little-endian fields, skips to the pixel data offset, and strips the 4-byte row padding. Emits an RGB pixel stream with frame and line markers. Sits between the file/DMA byte source and the image-processing pipeline, replacing bench-side header parsing.

---
 rtl/bmp_stream_parser.sv | 158 +++++++++++++++
 tb/tb_bmp_stream_parser.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bmp_stream_parser.sv
// bmp_stream_parser: BMP byte stream to RGB pixel stream with frame/line markers
// Ports: clk, rst_n (sync, active-low), restart; byte input s_data/s_valid/s_ready;
// pixel output m_pixel/m_valid/m_ready with m_sof/m_eol/m_eof; img_width, img_height,
// hdr_valid, err. Define BMP_TOPDOWN_EN to accept negative (top-down) heights.
module bmp_stream_parser #(
  parameter int MAX_WIDTH  = 4096,
  parameter int MAX_HEIGHT = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [23:0]      m_pixel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof,
  output logic [CNT_W-1:0] img_width,
  output logic [CNT_W-1:0] img_height,
  output logic             hdr_valid,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, HDR, SKIP, PIX, PAD, DONE, ERR} state_t;
  state_t state_q;
  logic [31:0] idx_q, off_q, wid_q, hgt_q, habs;
  logic [15:0] sig_q, bpp_q;
  logic [7:0] b_q, g_q, r_q;
  logic [1:0] bc_q, pad_q, pc_q;
  logic [CNT_W-1:0] col_q, row_q, img_w_q, img_h_q;
  logic [23:0] pix_q;
  logic mv_q, sof_q, eol_q, eof_q, hv_q, err_q;
  logic s_fire, m_fire, last_b, at_eol, at_eof, hdr_ok;
  logic [5:0] ko, kw, kh;
  assign s_ready = state_q == PIX ? (!mv_q || m_ready) : state_q != IDLE;
  assign s_fire = s_valid && s_ready;
  assign m_fire = mv_q && m_ready;
  assign last_b = bpp_q == 16'd32 ? bc_q == 2'd3 : bc_q == 2'd2;
  assign at_eol = col_q == img_w_q - CNT_W'(1);
  assign at_eof = at_eol && row_q == img_h_q - CNT_W'(1);
  assign ko = idx_q[5:0] - 6'd10;
  assign kw = idx_q[5:0] - 6'd18;
  assign kh = idx_q[5:0] - 6'd22;
`ifdef BMP_TOPDOWN_EN
  assign habs = hgt_q[31] ? -hgt_q : hgt_q;
`else
  // A negative height reads as a huge unsigned value and fails the range check.
  assign habs = hgt_q;
`endif
  assign hdr_ok = sig_q == 16'h4D42 && (bpp_q == 16'd24 || bpp_q == 16'd32) &&
                  wid_q != 32'd0 && wid_q <= 32'(MAX_WIDTH) &&
                  habs != 32'd0 && habs <= 32'(MAX_HEIGHT) && off_q >= 32'd54;
  assign m_pixel = pix_q;
  assign m_valid = mv_q;
  assign m_sof = sof_q;
  assign m_eol = eol_q;
  assign m_eof = eof_q;
  assign img_width = img_w_q;
  assign img_height = img_h_q;
  assign hdr_valid = hv_q;
  assign err = err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      off_q <= '0;
      wid_q <= '0;
      hgt_q <= '0;
      sig_q <= '0;
      bpp_q <= '0;
      b_q <= '0;
      g_q <= '0;
      r_q <= '0;
      bc_q <= '0;
      pad_q <= '0;
      pc_q <= '0;
      col_q <= '0;
      row_q <= '0;
      img_w_q <= '0;
      img_h_q <= '0;
      pix_q <= '0;
      mv_q <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      eof_q <= 1'b0;
      hv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (m_fire) mv_q <= 1'b0;
      if (s_fire) idx_q <= idx_q + 32'd1;
      case (state_q)
        IDLE: begin
          idx_q <= '0;
          col_q <= '0;
          row_q <= '0;
          bc_q <= '0;
          pc_q <= '0;
          state_q <= HDR;
        end
        HDR: if (s_fire) begin
          if (idx_q < 32'd2) sig_q[{idx_q[0], 3'b000} +: 8] <= s_data;
          if (idx_q >= 32'd10 && idx_q <= 32'd13) off_q[{ko[1:0], 3'b000} +: 8] <= s_data;
          if (idx_q >= 32'd18 && idx_q <= 32'd21) wid_q[{kw[1:0], 3'b000} +: 8] <= s_data;
          if (idx_q >= 32'd22 && idx_q <= 32'd25) hgt_q[{kh[1:0], 3'b000} +: 8] <= s_data;
          if (idx_q == 32'd28 || idx_q == 32'd29) bpp_q[{idx_q[0], 3'b000} +: 8] <= s_data;
          if (idx_q == 32'd53) begin
            if (hdr_ok) begin
              hv_q <= 1'b1;
              img_w_q <= wid_q[CNT_W-1:0];
              img_h_q <= habs[CNT_W-1:0];
              // 24bpp: (4 - 3w mod 4) mod 4 == w mod 4; 32bpp rows are always aligned.
              pad_q <= bpp_q == 16'd32 ? 2'd0 : wid_q[1:0];
              state_q <= off_q == 32'd54 ? PIX : SKIP;
            end else begin
              err_q <= 1'b1;
              mv_q <= 1'b0;
              state_q <= ERR;
            end
          end
        end
        SKIP: if (s_fire && idx_q + 32'd1 == off_q) state_q <= PIX;
        PIX: if (s_fire) begin
          bc_q <= last_b ? 2'd0 : bc_q + 2'd1;
          if (bc_q == 2'd0) b_q <= s_data;
          if (bc_q == 2'd1) g_q <= s_data;
          if (bc_q == 2'd2) r_q <= s_data;
          if (last_b) begin
            pix_q <= {bpp_q == 16'd32 ? r_q : s_data, g_q, b_q};
            mv_q <= 1'b1;
            sof_q <= col_q == '0 && row_q == '0;
            eol_q <= at_eol;
            eof_q <= at_eof;
            col_q <= at_eol ? '0 : col_q + CNT_W'(1);
            if (at_eol) row_q <= row_q + CNT_W'(1);
            if (at_eol && pad_q != 2'd0) state_q <= PAD;
            else if (at_eof) state_q <= DONE;
          end
        end
        PAD: if (s_fire) begin
          pc_q <= pc_q + 2'd1;
          if (pc_q + 2'd1 == pad_q) begin
            pc_q <= 2'd0;
            state_q <= row_q == img_h_q ? DONE : PIX;
          end
        end
        DONE, ERR: if (restart) begin
          err_q <= 1'b0;
          hv_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bmp_stream_parser.sv
// tb_bmp_stream_parser: directed self-checking bench for bmp_stream_parser
module tb_bmp_stream_parser;
  logic clk = 1'b0, rst_n = 1'b0, restart = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic [7:0] s_data = 8'h0;
  logic s_ready, m_valid, m_sof, m_eol, m_eof, hdr_valid, err;
  logic [23:0] m_pixel;
  logic [15:0] img_width, img_height;
  logic [26:0] got [$];
  int passed = 0, total = 0, fails = 0;

  bmp_stream_parser dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_pixel(m_pixel), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .img_width(img_width),
    .img_height(img_height), .hdr_valid(hdr_valid), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && m_valid && m_ready) got.push_back({m_sof, m_eol, m_eof, m_pixel});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    s_data = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8]);
  endtask

  task automatic send_hdr(input logic [15:0] sig, input logic [31:0] off, input logic [31:0] w,
                          input logic [31:0] h, input logic [15:0] bpp);
    logic [7:0] hb [54];
    foreach (hb[i]) hb[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      hb[i] = sig[8*i +: 8];
      hb[28+i] = bpp[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      hb[10+i] = off[8*i +: 8];
      hb[18+i] = w[8*i +: 8];
      hb[22+i] = h[8*i +: 8];
    end
    for (int i = 0; i < 54; i++) send(hb[i]);
  endtask

  task automatic pulse_restart();
    @(posedge clk);
    #1 restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_px(input string tag, input int i, input logic [26:0] exp);
    chk(tag, got.size() > i ? {5'd0, got[i]} : 32'hDEAD, {5'd0, exp});
  endtask

  task automatic chk_2x2(input string tag);
    chk({tag, "_count"}, got.size(), 32'd4);
    chk_px({tag, "_px0"}, 0, {3'b100, 24'h030201});
    chk_px({tag, "_px1"}, 1, {3'b010, 24'h060504});
    chk_px({tag, "_px2"}, 2, {3'b000, 24'h090807});
    chk_px({tag, "_px3"}, 3, {3'b011, 24'h0C0B0A});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_hdr_valid", {31'd0, hdr_valid}, 32'd0);
    chk("rst_img_width", {16'd0, img_width}, 32'd0);
    chk("rst_m_pixel", {8'd0, m_pixel}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", {31'd0, s_ready}, 32'd0);

    send_hdr(16'h4D42, 32'd54, 32'd2, 32'd2, 16'd24);
    chk("t1_hdr_valid", {31'd0, hdr_valid}, 32'd1);
    chk("t1_img_width", {16'd0, img_width}, 32'd2);
    chk("t1_img_height", {16'd0, img_height}, 32'd2);
    send_seq(128'h0102030405060000, 8);
    send_seq(128'h0708090A0B0C0000, 8);
    send(8'h55);
    wait_cycles(3);
    chk_2x2("t1");
    chk("t1_done_s_ready", {31'd0, s_ready}, 32'd1);
    pulse_restart();
    chk("t1_restart_hdr_valid", {31'd0, hdr_valid}, 32'd0);
    got.delete();

    send_hdr(16'h4D42, 32'd54, 32'd3, 32'd1, 16'd32);
    send_seq(128'h102030FF112131FF122232FF, 12);
    wait_cycles(3);
    chk("t2_count", got.size(), 32'd3);
    chk_px("t2_px0", 0, {3'b100, 24'h302010});
    chk_px("t2_px1", 1, {3'b000, 24'h312111});
    chk_px("t2_px2", 2, {3'b011, 24'h322212});
    pulse_restart();
    got.delete();

    send_hdr(16'h4142, 32'd54, 32'd2, 32'd2, 16'd24);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_hdr_valid", {31'd0, hdr_valid}, 32'd0);
    chk("t3_s_ready", {31'd0, s_ready}, 32'd1);
    send_seq(128'h010203040506, 6);
    chk("t3_no_pixels", got.size(), 32'd0);
    chk("t3_m_valid", {31'd0, m_valid}, 32'd0);
    pulse_restart();
    chk("t3_err_cleared", {31'd0, err}, 32'd0);
    chk("t3_idle_s_ready", {31'd0, s_ready}, 32'd0);

    send_hdr(16'h4D42, 32'd60, 32'd1, 32'd1, 16'd24);
    send_seq(128'hEEEEEEEEEEEE, 6);
    send_seq(128'hAABBCC00, 4);
    wait_cycles(3);
    chk("t4_count", got.size(), 32'd1);
    chk_px("t4_px0", 0, {3'b111, 24'hCCBBAA});
    pulse_restart();
    got.delete();

    send_hdr(16'h4D42, 32'd54, 32'd2, 32'd2, 16'd24);
    m_ready = 1'b0;
    send_seq(128'h010203, 3);
    s_data = 8'h04;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stall_s_ready", {31'd0, s_ready}, 32'd0);
      chk("t5_stall_pixel", {7'd0, m_valid, m_pixel}, {7'd0, 1'b1, 24'h030201});
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    send_seq(128'h0405060000, 5);
    send_seq(128'h0708090A0B0C0000, 8);
    wait_cycles(3);
    chk_2x2("t5");
    pulse_restart();
    got.delete();

    send_hdr(16'h4D42, 32'd54, 32'd2, 32'd2, 16'd24);
    m_ready = 1'b0;
    send_seq(128'h010203, 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_s_ready", {31'd0, s_ready}, 32'd0);
    chk("t6_hdr_valid", {31'd0, hdr_valid}, 32'd0);
    chk("t6_img_height", {16'd0, img_height}, 32'd0);
    chk("t6_m_pixel", {8'd0, m_pixel}, 32'd0);
    chk("t6_m_sof", {31'd0, m_sof}, 32'd0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    got.delete();
    send_hdr(16'h4D42, 32'd54, 32'd2, 32'd2, 16'd24);
    send_seq(128'h0102030405060000, 8);
    send_seq(128'h0708090A0B0C0000, 8);
    wait_cycles(3);
    chk_2x2("t6");
    pulse_restart();
    got.delete();

    send_hdr(16'h4D42, 32'd54, 32'd2, 32'hFFFFFFFE, 16'd24);
`ifdef BMP_TOPDOWN_EN
    chk("t7_hdr_valid", {31'd0, hdr_valid}, 32'd1);
    chk("t7_img_height", {16'd0, img_height}, 32'd2);
    send_seq(128'h0102030405060000, 8);
    send_seq(128'h0708090A0B0C0000, 8);
    wait_cycles(3);
    chk_2x2("t7");
`else
    chk("t7_err", {31'd0, err}, 32'd1);
    chk("t7_hdr_valid", {31'd0, hdr_valid}, 32'd0);
`endif
    pulse_restart();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
